// File: rtl/siso.sv
// ---------------------------------------------------------------------------
// siso -- serial-in / serial-out shift register
//
// Shifts s_in through a chain of `bits` flip-flops on every rising edge of
// clk; s_out is taken directly from the last stage, so there is no
// combinational path from input to output and the latency is exactly
// `bits` edges.
//
// Parameters
//   bits   : chain depth in flip-flops (>= 1)
//
// Ports
//   clk    : sole clock, rising edge
//   rst    : synchronous active-high reset, clears every stage
//   s_in   : serial data in, sampled each rising edge into stage 0
//   s_out  : serial data out, stage bits-1
// ---------------------------------------------------------------------------
module siso #(
  parameter int unsigned bits = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic s_in,
  output logic s_out
);

  // Stage 0 is the input end, stage bits-1 the output end.
  logic [bits-1:0] r_stage;

  // A one-stage chain has no [bits-2:0] slice to concatenate, so it gets its
  // own branch; both branches shift on every non-reset edge.
  if (bits == 1) begin : g_one
    always_ff @(posedge clk) begin
      if (rst) begin
        r_stage <= '0;
      end else begin
        r_stage <= s_in;
      end
    end
  end else begin : g_multi
    always_ff @(posedge clk) begin
      if (rst) begin
        r_stage <= '0;
      end else begin
        r_stage <= {r_stage[bits-2:0], s_in};
      end
    end
  end

  assign s_out = r_stage[bits-1];

endmodule

// File: tb/tb_siso.sv
// ---------------------------------------------------------------------------
// tb_siso -- self-checking bench for siso at depths 8, 1 and 16.
//
// All three instances share clk, rst and s_in. The reference keeps a log of
// what was presented on every rising edge and derives the expected output
// as: the s_in sampled bits-1 edges ago, unless any edge in that window was
// a reset edge, in which case 0.
// ---------------------------------------------------------------------------
module tb_siso;

  logic clk;
  logic rst;
  logic s_in;
  logic w_out8;
  logic w_out1;
  logic w_out16;

  int unsigned n_cmp;
  int unsigned n_err;

  bit hist_in[$];
  bit hist_rst[$];

  siso #(.bits(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .s_in  (s_in),
    .s_out (w_out8)
  );

  siso #(.bits(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .s_in  (s_in),
    .s_out (w_out1)
  );

  siso #(.bits(16)) u_dut16 (
    .clk   (clk),
    .rst   (rst),
    .s_in  (s_in),
    .s_out (w_out16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (edge %0d)", tag, got, exp,
               hist_in.size());
    end
  endtask

  // Expected output of a depth-b chain after the most recent logged edge.
  function automatic bit model(input int b);
    int n;
    int s;
    n = hist_in.size() - 1;
    s = n - b + 1;
    if (s < 0) return 1'b0;
    for (int k = s; k <= n; k++) begin
      if (hist_rst[k]) return 1'b0;
    end
    return hist_in[s];
  endfunction

  // Present inputs away from the edge, log the edge, check just after it.
  task automatic step(input string tag, input logic r, input logic d);
    @(negedge clk);
    rst  = r;
    s_in = d;
    @(posedge clk);
    hist_in.push_back(d);
    hist_rst.push_back(r);
    #1;
    check({tag, "/b8"},  w_out8,  model(8));
    check({tag, "/b1"},  w_out1,  model(1));
    check({tag, "/b16"}, w_out16, model(16));
  endtask

  initial begin
    logic [7:0] pat;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    s_in  = 1'b1;

    // Reset with s_in high: outputs must be 0 after the first reset edge.
    step("reset", 1'b1, 1'b1);
    check("reset_b8_zero", w_out8, 1'b0);
    step("reset", 1'b1, 1'b0);

    // Pattern 1,1,0,0,1,0,1,1 then zeros; also fully drains the 16-deep chain.
    pat = 8'b1100_1011;
    for (int i = 0; i < 8; i++) step("pattern", 1'b0, pat[7-i]);
    for (int i = 0; i < 16; i++) step("pattern_tail", 1'b0, 1'b0);

    // Single pulse after reset.
    step("pulse_rst", 1'b1, 1'b0);
    step("pulse", 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) step("pulse_tail", 1'b0, 1'b0);

    // Mid-stream reset discards in-flight ones.
    for (int i = 0; i < 4; i++) step("mid_fill", 1'b0, 1'b1);
    step("mid_rst", 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step("mid_drain", 1'b0, 1'b0);
      check("mid_drain_b8_zero", w_out8, 1'b0);
    end

    // Constant one after reset.
    step("const_rst", 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step("const", 1'b0, 1'b1);
    check("const_b16_one", w_out16, 1'b1);

    // Random data with occasional reset edges.
    step("rand_rst", 1'b1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/siso.md
SISO -- requirements
Module: siso

Interface
REQ-001 Parameter: bits, default 8, shift-register depth in flip-flops; legal range bits >= 1.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge only.
REQ-003 Port: rst  input  1  reset, synchronous, active-high; sampled on the rising edge of clk.
REQ-004 Port: s_in  input  1  serial data input, sampled on each rising edge of clk.
REQ-005 Port: s_out  output  1  serial data output, driven directly from the last register stage.

Function
REQ-006 Storage SHALL be a bits-wide register chain, stage 0 (input end) through stage bits-1 (output end).
REQ-007 On a rising edge with rst=0, stage 0 SHALL load s_in, and each stage i (1..bits-1) SHALL load the prior value of stage i-1, all simultaneously.
REQ-008 s_out SHALL equal stage bits-1 at all times, with no combinational path from s_in to s_out.
REQ-009 Latency SHALL be exactly bits rising edges: a bit sampled at edge n appears on s_out after edge n+bits-1 and holds until edge n+bits.
REQ-010 For bits=1, s_out SHALL be s_in delayed by one rising edge.
REQ-011 Bit order SHALL be preserved, first-in first-out; no inversion, reordering or loss.
REQ-012 The shift SHALL occur on every non-reset rising edge, with no enable or hold mode.
REQ-013 Output changes SHALL occur only just after rising edges of clk.

Reset
REQ-014 On a rising edge with rst=1, all bits stages SHALL clear to 0, so s_out=0 after that edge.
REQ-015 rst SHALL take priority over shifting; s_in is ignored on reset edges.
REQ-016 Reset asserted mid-stream SHALL discard all in-flight bits; after release, bits edges of s_in=0 keep s_out=0.
REQ-017 Before the first reset edge, register contents are undefined, and s_out need not be known.
REQ-018 Deasserting rst SHALL take effect at the next rising edge; the first non-reset edge samples s_in into stage 0.

Verification
REQ-019 Reset: rst=1 for 2 edges, any s_in -> s_out=0 after the first reset edge.
REQ-020 Pattern: after reset, drive 1,1,0,0,1,0,1,1 on edges 1-8, then 0 for 8 edges, bits=8 -> s_out=0 through edge 7, then s_out reads 1,1,0,0,1,0,1,1 after edges 8-15, then 0 after edge 16.
REQ-021 Single pulse: after reset, s_in=1 for one edge, then 0 -> s_out=1 only after edge 8 (bits=8); 0 at all other times.
REQ-022 Mid-stream reset: shift in 1,1,1,1, then assert rst for one edge, then feed 0s -> s_out stays 0 for the next 8 edges.
REQ-023 Parameter sweep: bits=1 and bits=16 with random s_in -> s_out equals s_in delayed by exactly bits edges, checked by a reference delay-line model every cycle.
REQ-024 Constant input: after reset, s_in=1 continuously -> s_out=0 after edges 1 to bits-1, then 1 from edge bits onward.
